mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/slc3_mem_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_rr_pick.sv | 13 +
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, port indices
// and default widths.
package slc3_mem_pkg;
  localparam int DEF_ADDR_W     = 20;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ACC_CYCLES = 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and SRAM bus bundle for the two-port arbiter.
// Handshake: a requester raises req with addr/we/wdata and holds all of them
// until its one-cycle done pulse; rdata is valid from that pulse onward.
interface mem_arbiter_if #(
  parameter int ADDR_W = slc3_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = slc3_mem_pkg::DEF_DATA_W
);
  logic              cpu_req,   dma_req;
  logic              cpu_we,    dma_we;
  logic [ADDR_W-1:0] cpu_addr,  dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_done,  dma_done;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [ADDR_W-1:0] Mem_ADDR;
  logic [DATA_W-1:0] Mem_Dout;
  logic              Mem_Dout_en;
  logic [DATA_W-1:0] Mem_Din;
  logic              owner;

  modport master (
    output cpu_req, dma_req, cpu_we, dma_we, cpu_addr, dma_addr,
           cpu_wdata, dma_wdata, Mem_Din,
    input  cpu_done, dma_done, cpu_rdata, dma_rdata, Mem_CE, Mem_UB,
           Mem_LB, Mem_OE, Mem_WE, Mem_ADDR, Mem_Dout, Mem_Dout_en, owner
  );

  modport slave (
    input  cpu_req, dma_req, cpu_we, dma_we, cpu_addr, dma_addr,
           cpu_wdata, dma_wdata, Mem_Din,
    output cpu_done, dma_done, cpu_rdata, dma_rdata, Mem_CE, Mem_UB,
           Mem_LB, Mem_OE, Mem_WE, Mem_ADDR, Mem_Dout, Mem_Dout_en, owner
  );
endinterface

// File: rtl/mem_rr_pick.sv
// Two-way round-robin pick: on a tie the port not granted last time wins.
module mem_rr_pick (
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last,
  output logic grant,
  output logic winner
);
  import slc3_mem_pkg::*;

  assign grant  = cpu_req | dma_req;
  assign winner = (cpu_req & dma_req) ? ~last : (dma_req ? PORT_DMA : PORT_CPU);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA access to one asynchronous SRAM; every access is
// IDLE -> ACCESS (ACC_CYCLES) -> DONE, with all SRAM outputs registered.
module mem_arbiter #(
  parameter int ADDR_W     = slc3_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W     = slc3_mem_pkg::DEF_DATA_W,
  parameter int ACC_CYCLES = slc3_mem_pkg::DEF_ACC_CYCLES
) (
  input  logic                 Clk,
  input  logic                 Reset,
  mem_arbiter_if.slave         bus,
  output slc3_mem_pkg::state_t dbg_state
);
  import slc3_mem_pkg::*;

  localparam logic [2:0] LAST_CNT = 3'(ACC_CYCLES - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic              last;
  logic              owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              we_r;
  logic              ce_n, oe_n, we_n, dout_en;
  logic              cpu_done_r, dma_done_r;
  logic [DATA_W-1:0] cpu_rdata_r, dma_rdata_r;
  logic              grant, winner;
  logic              sel_we;

  mem_rr_pick u_pick (
    .cpu_req (bus.cpu_req),
    .dma_req (bus.dma_req),
    .last    (last),
    .grant   (grant),
    .winner  (winner)
  );

  assign sel_we = (winner == PORT_DMA) ? bus.dma_we : bus.cpu_we;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      last        <= PORT_DMA;
      owner_r     <= PORT_CPU;
      addr_r      <= '0;
      wdata_r     <= '0;
      we_r        <= 1'b0;
      ce_n        <= 1'b1;
      oe_n        <= 1'b1;
      we_n        <= 1'b1;
      dout_en     <= 1'b0;
      cpu_done_r  <= 1'b0;
      dma_done_r  <= 1'b0;
      cpu_rdata_r <= '0;
      dma_rdata_r <= '0;
    end else begin
      cpu_done_r <= 1'b0;
      dma_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner_r <= winner;
            last    <= winner;
            addr_r  <= (winner == PORT_DMA) ? bus.dma_addr  : bus.cpu_addr;
            wdata_r <= (winner == PORT_DMA) ? bus.dma_wdata : bus.cpu_wdata;
            we_r    <= sel_we;
            cnt     <= 3'd0;
            ce_n    <= 1'b0;
            oe_n    <= sel_we;
            we_n    <= ~sel_we;
            dout_en <= sel_we;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == LAST_CNT) begin
            // Strobes rise here so DONE doubles as the bus-turnaround cycle.
            ce_n    <= 1'b1;
            oe_n    <= 1'b1;
            we_n    <= 1'b1;
            dout_en <= 1'b0;
            if (!we_r) begin
              if (owner_r == PORT_DMA) dma_rdata_r <= bus.Mem_Din;
              else                     cpu_rdata_r <= bus.Mem_Din;
            end
            if (owner_r == PORT_DMA) dma_done_r <= 1'b1;
            else                     cpu_done_r <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          cnt   <= 3'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Mem_CE      = ce_n;
  assign bus.Mem_UB      = ce_n;
  assign bus.Mem_LB      = ce_n;
  assign bus.Mem_OE      = oe_n;
  assign bus.Mem_WE      = we_n;
  assign bus.Mem_Dout_en = dout_en;
  assign bus.Mem_ADDR    = addr_r;
  assign bus.Mem_Dout    = wdata_r;
  assign bus.owner       = owner_r;
  assign bus.cpu_done    = cpu_done_r;
  assign bus.dma_done    = dma_done_r;
  assign bus.cpu_rdata   = cpu_rdata_r;
  assign bus.dma_rdata   = dma_rdata_r;
  assign dbg_state       = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with ACC_CYCLES = 2: one linear sequence of
// steps, each checked against hand-computed values.
module tb_mem_arbiter;
  import slc3_mem_pkg::*;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  localparam logic [5:0] STB_IDLE  = 6'b111110; // {CE,UB,LB,OE,WE,Dout_en}
  localparam logic [5:0] STB_READ  = 6'b000010;
  localparam logic [5:0] STB_WRITE = 6'b000101;

  logic   Clk;
  logic   Reset;
  state_t dbg_state;
  int     total_cnt;
  int     pass_cnt;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYCLES(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of sequence, required finish before 200000");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.dma_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.dma_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.dma_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_wdata = '0;
  endtask

  function automatic logic [5:0] strb();
    return {bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE, bus.Mem_Dout_en};
  endfunction

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp_v);
  endtask

  initial begin
    total_cnt   = 0;
    pass_cnt    = 0;
    Reset       = 1'b1;
    bus.Mem_Din = '0;
    idle_inputs();
    tick();
    tick();
    Reset = 1'b0;

    // reset state
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_strobes", 32'(strb()), 32'(STB_IDLE));
    chk("rst_done", {bus.cpu_done, bus.dma_done}, 32'd0);
    chk("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 32'd0);
    chk("rst_addr", 32'(bus.Mem_ADDR), 32'd0);
    chk("rst_dout", 32'(bus.Mem_Dout), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);

    // CPU read of 0x0FFFF
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 20'h0FFFF;
    bus.Mem_Din  = 16'h1234;
    tick();
    chk("rd_strb_t1", 32'(strb()), 32'(STB_READ));
    chk("rd_addr_t1", 32'(bus.Mem_ADDR), 32'h0FFFF);
    chk("rd_owner", 32'(bus.owner), 32'd0);
    chk("rd_state_t1", 32'(dbg_state), 32'(ACCESS));
    tick();
    chk("rd_strb_t2", 32'(strb()), 32'(STB_READ));
    chk("rd_done_t2", {bus.cpu_done, bus.dma_done}, 32'd0);
    tick();
    chk("rd_done_t3", {bus.cpu_done, bus.dma_done}, 32'b10);
    chk("rd_rdata", 32'(bus.cpu_rdata), 32'h1234);
    chk("rd_strb_t3", 32'(strb()), 32'(STB_IDLE));
    bus.cpu_req = 1'b0;
    tick();
    chk("rd_idle", 32'(dbg_state), 32'(IDLE));
    chk("rd_done_t4", {bus.cpu_done, bus.dma_done}, 32'd0);

    // DMA write of 0xBEEF to 0x00010
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 20'h00010;
    bus.dma_wdata = 16'hBEEF;
    tick();
    chk("wr_strb_t1", 32'(strb()), 32'(STB_WRITE));
    chk("wr_addr_t1", 32'(bus.Mem_ADDR), 32'h00010);
    chk("wr_dout_t1", 32'(bus.Mem_Dout), 32'hBEEF);
    chk("wr_owner", 32'(bus.owner), 32'd1);
    tick();
    chk("wr_strb_t2", 32'(strb()), 32'(STB_WRITE));
    chk("wr_dout_t2", 32'(bus.Mem_Dout), 32'hBEEF);
    tick();
    chk("wr_done_t3", {bus.cpu_done, bus.dma_done}, 32'b01);
    chk("wr_strb_t3", 32'(strb()), 32'(STB_IDLE));
    chk("wr_cpu_rdata_kept", 32'(bus.cpu_rdata), 32'h1234);
    chk("wr_dma_rdata_kept", 32'(bus.dma_rdata), 32'h0000);
    bus.dma_req = 1'b0;
    tick();

    // address input changes mid-access
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 20'h00001;
    bus.Mem_Din  = 16'hA001;
    tick();
    bus.cpu_addr = 20'h00002;
    chk("hold_addr_t1", 32'(bus.Mem_ADDR), 32'h00001);
    tick();
    chk("hold_addr_t2", 32'(bus.Mem_ADDR), 32'h00001);
    tick();
    chk("hold_addr_done", 32'(bus.Mem_ADDR), 32'h00001);
    chk("hold_done", 32'(bus.cpu_done), 32'd1);
    chk("hold_rdata", 32'(bus.cpu_rdata), 32'hA001);
    bus.cpu_req = 1'b0;
    tick();

    // write then an immediate read from the same held request
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 20'h00005;
    bus.cpu_wdata = 16'h7777;
    tick();
    chk("wr2_strb", 32'(strb()), 32'(STB_WRITE));
    tick();
    tick();
    chk("turn_done_strb", 32'(strb()), 32'(STB_IDLE));
    chk("turn_done_pulse", 32'(bus.cpu_done), 32'd1);
    bus.cpu_we  = 1'b0;
    bus.Mem_Din = 16'h5A5A;
    tick();
    chk("turn_idle_strb", 32'(strb()), 32'(STB_IDLE));
    chk("turn_idle_state", 32'(dbg_state), 32'(IDLE));
    tick();
    chk("rd2_strb", 32'(strb()), 32'(STB_READ));
    chk("rd2_addr", 32'(bus.Mem_ADDR), 32'h00005);
    tick();
    tick();
    chk("rd2_done", 32'(bus.cpu_done), 32'd1);
    chk("rd2_rdata", 32'(bus.cpu_rdata), 32'h5A5A);
    bus.cpu_req = 1'b0;
    tick();

    // both requesting continuously from reset: CPU wins first, then alternate
    bus.cpu_req = 1'b1;
    bus.dma_req = 1'b1;
    bus.cpu_we  = 1'b0;
    bus.dma_we  = 1'b0;
    Reset       = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rr_rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.Mem_Din = 16'h1000 + 16'(i);
      tick();
      chk($sformatf("rr_owner_%0d", i), 32'(bus.owner), 32'(i % 2));
      tick();
      tick();
      chk($sformatf("rr_done_%0d", i), {bus.cpu_done, bus.dma_done},
          (i % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("rr_rdata_%0d", i),
          (i % 2 == 0) ? 32'(bus.cpu_rdata) : 32'(bus.dma_rdata), 32'h1000 + 32'(i));
      tick();
    end

    // reset during second ACCESS cycle of a CPU read
    bus.dma_req = 1'b0;
    Reset       = 1'b1;
    tick();
    Reset       = 1'b0;
    bus.Mem_Din = 16'hDEAD;
    tick();
    chk("irq_access", 32'(dbg_state), 32'(ACCESS));
    tick();
    Reset = 1'b1;
    tick();
    chk("irq_state", 32'(dbg_state), 32'(IDLE));
    chk("irq_strb", 32'(strb()), 32'(STB_IDLE));
    chk("irq_done", {bus.cpu_done, bus.dma_done}, 32'd0);
    chk("irq_rdata", 32'(bus.cpu_rdata), 32'd0);
    bus.cpu_req = 1'b0;
    Reset       = 1'b0;
    tick();
    chk("irq_done_after", {bus.cpu_done, bus.dma_done}, 32'd0);
    chk("irq_rdata_after", 32'(bus.cpu_rdata), 32'd0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
